// File: rtl/count_run_controller.sv
// -----------------------------------------------------------------------------
// count_run_controller
//
// Run/pause/clear sequencer for the seven-segment count display. The count is
// held as packed BCD digits, so the display path needs no divide or modulo.
// While running, the count steps once per slw_clk edge, up or down. At the
// terminal count it either wraps and keeps running (WRAP=1) or stops in DONE
// (WRAP=0).
//
// Parameters:
//   DIGITS     number of BCD digits held and driven
//   MAX_COUNT  terminal count in decimal, 1 .. 10^DIGITS-1
//   WRAP       1 = wrap at terminal and keep running, 0 = stop in DONE
//
// Ports:
//   slw_clk     in   count/step clock (slow tick)
//   reset       in   asynchronous, active-high
//   start_btn   in   start/resume request (async level)
//   stop_btn    in   pause request (async level)
//   clear_btn   in   clear-to-zero request (async level)
//   up_down     in   1 = count up, 0 = count down (async level)
//   lap_btn     in   lap snapshot toggle (async level, COUNT_LAP_EN only)
//   lap_active  out  display shows the lap snapshot (COUNT_LAP_EN only)
//   bcd_digits  out  displayed count, digit i at [4i+3:4i], digit 0 = LSD
//   digit_en    out  per-digit display enable with leading-zero blanking
//   running     out  state is RUN
//   at_limit    out  count is at the terminal for the current direction
//   wrap_pulse  out  one-cycle strobe after a wrap step
//
// Optional feature: define COUNT_LAP_EN to add the lap snapshot display.
// -----------------------------------------------------------------------------
module count_run_controller #(
  parameter int DIGITS    = 4,
  parameter int MAX_COUNT = 50,
  parameter int WRAP      = 1
) (
  input  logic                  slw_clk,
  input  logic                  reset,
  input  logic                  start_btn,
  input  logic                  stop_btn,
  input  logic                  clear_btn,
  input  logic                  up_down,
`ifdef COUNT_LAP_EN
  input  logic                  lap_btn,
  output logic                  lap_active,
`endif
  output logic [4*DIGITS-1:0]   bcd_digits,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  running,
  output logic                  at_limit,
  output logic                  wrap_pulse
);

  localparam int W = 4 * DIGITS;

  function automatic logic [W-1:0] to_bcd(input int value);
    logic [W-1:0] r;
    int           v;
    r = '0;
    v = value;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v           = v / 10;
    end
    return r;
  endfunction

  localparam logic [W-1:0] MAX_BCD = to_bcd(MAX_COUNT);

  // Ripple increment/decrement: carry or borrow moves through all digits in
  // one cycle. Terminal handling is done by the caller, so no overflow here.
  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         c;
    r = v;
    c = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (c) begin
        if (r[4*k +: 4] == 4'd9) begin
          r[4*k +: 4] = 4'd0;
        end else begin
          r[4*k +: 4] = r[4*k +: 4] + 4'd1;
          c           = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         b;
    r = v;
    b = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (b) begin
        if (r[4*k +: 4] == 4'd0) begin
          r[4*k +: 4] = 4'd9;
        end else begin
          r[4*k +: 4] = r[4*k +: 4] - 4'd1;
          b           = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // ---------------------------------------------------------------- inputs
  // Button vector order: {[lap,] clear, stop, start}.
`ifdef COUNT_LAP_EN
  localparam int NB = 4;
  logic [NB-1:0] btn_raw;
  assign btn_raw = {lap_btn, clear_btn, stop_btn, start_btn};
`else
  localparam int NB = 3;
  logic [NB-1:0] btn_raw;
  assign btn_raw = {clear_btn, stop_btn, start_btn};
`endif

  logic [NB-1:0] s1_q, s2_q, s3_q, btn_ev;
  logic          ud_s1_q, ud_s2_q;

  always_ff @(posedge slw_clk or posedge reset) begin
    if (reset) begin
      s1_q    <= '0;
      s2_q    <= '0;
      s3_q    <= '0;
      ud_s1_q <= 1'b0;
      ud_s2_q <= 1'b0;
    end else begin
      s1_q    <= btn_raw;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      ud_s1_q <= up_down;
      ud_s2_q <= ud_s1_q;
    end
  end

  // Rising edge of the synchronized level: one event per press, no repeat.
  assign btn_ev = s2_q & ~s3_q;

  logic start_ev, stop_ev, clear_ev;
  assign start_ev = btn_ev[0];
  assign stop_ev  = btn_ev[1];
  assign clear_ev = btn_ev[2];

  // ---------------------------------------------------------------- core FSM
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t       state_q, state_d;
  logic [W-1:0] count_q, count_d;
  logic         wrap_q, wrap_d;
  logic         at_term;

  assign at_term = ud_s2_q ? (count_q == MAX_BCD) : (count_q == '0);

  always_ff @(posedge slw_clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    wrap_d  = 1'b0;
    if (clear_ev) begin
      state_d = IDLE;
      count_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          count_d = '0;
          if (start_ev) state_d = RUN;
        end
        RUN: begin
          if (stop_ev) begin
            state_d = PAUSE;
          end else if (at_term) begin
            if (WRAP != 0) begin
              count_d = ud_s2_q ? '0 : MAX_BCD;
              wrap_d  = 1'b1;
            end else begin
              state_d = DONE;
            end
          end else begin
            count_d = ud_s2_q ? bcd_inc(count_q) : bcd_dec(count_q);
          end
        end
        PAUSE: begin
          if (start_ev) state_d = RUN;
        end
        DONE: begin
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- display
  logic [W-1:0] disp;

`ifdef COUNT_LAP_EN
  logic [W-1:0] snap_q, snap_d;
  logic         lap_q, lap_d;

  always_ff @(posedge slw_clk or posedge reset) begin
    if (reset) begin
      snap_q <= '0;
      lap_q  <= 1'b0;
    end else begin
      snap_q <= snap_d;
      lap_q  <= lap_d;
    end
  end

  // Lap is lowest priority: it only acts on an edge with no other event.
  always_comb begin
    snap_d = snap_q;
    lap_d  = lap_q;
    if (clear_ev) begin
      lap_d = 1'b0;
    end else if (btn_ev[3] && !stop_ev && !start_ev) begin
      if (lap_q) begin
        lap_d = 1'b0;
      end else if (state_q == RUN) begin
        snap_d = count_q;
        lap_d  = 1'b1;
      end
    end
  end

  assign disp       = lap_q ? snap_q : count_q;
  assign lap_active = lap_q;
`else
  assign disp = count_q;
`endif

  assign bcd_digits = disp;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_en
      if (gi == 0) begin : g_lsd
        assign digit_en[gi] = 1'b1;
      end else begin : g_upper
        assign digit_en[gi] = |disp[W-1:4*gi];
      end
    end
  endgenerate

  // In IDLE the count is forced to zero and carries no terminal meaning.
  assign running    = (state_q == RUN);
  assign at_limit   = (state_q != IDLE) && at_term;
  assign wrap_pulse = wrap_q;

endmodule
